hilo_muldiv_unit: RTL and testbench

Parametrised successor to the single-cycle HI/LO holding register. It owns the HI/LO pair and adds an iterative multiply/divide engine, MTHI/MTLO writes and a valid/ready handshake, so the execute stage can stall on busy. It sits in the executing core beside the ALU; mfhi/mflo read out_hi/out_lo directly.

---
 rtl/hilo_pkg.sv | 36 +++
 rtl/hilo_muldiv_unit_if.sv | 33 +++
 rtl/hilo_iter_core.sv | 96 +++++++++
 rtl/hilo_muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// -----------------------------------------------------------------------------
// hilo_pkg
// Shared types for the HI/LO multiply/divide unit.
//   hilo_op_e    : op_code encoding seen on the request bus
//   hilo_state_e : control FSM states (IDLE / MUL / DIV / FIX)
//   hilo_cnt_w() : width of the iteration counter for a given operand width
// -----------------------------------------------------------------------------
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } hilo_state_e;

    localparam int HILO_DW_DEFAULT = 32;
    localparam int HILO_CNT_W      = $clog2(HILO_DW_DEFAULT + 1);

    // Iteration counter width for an arbitrary operand width.
    function automatic int hilo_cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit_if
// Request/response bundle between the execute stage (master) and the HI/LO
// multiply/divide unit (slave).
//   op_valid/op_ready          : request handshake, accept when both high
//   op_code, operand_a/b       : request payload, sampled at the accept edge
//   busy, done, div_by_zero    : status (done/div_by_zero are 1-cycle pulses)
//   out_hi, out_lo             : current HI / LO contents
// -----------------------------------------------------------------------------
interface hilo_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  op_valid;
    logic                  op_ready;
    logic [2:0]            op_code;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;
    logic [DATA_WIDTH-1:0] out_hi;
    logic [DATA_WIDTH-1:0] out_lo;

    modport master (
        output op_valid, op_code, operand_a, operand_b,
        input  op_ready, busy, done, div_by_zero, out_hi, out_lo
    );

    modport slave (
        input  op_valid, op_code, operand_a, operand_b,
        output op_ready, busy, done, div_by_zero, out_hi, out_lo
    );
endinterface

// File: rtl/hilo_iter_core.sv
// -----------------------------------------------------------------------------
// hilo_iter_core
// Shared iterative datapath: one shift register pair (r/q) plus a single
// adder/subtractor, used for unsigned shift-add multiply (mode_i=0) and
// unsigned restoring division (mode_i=1). One bit per step_i cycle.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   load_i       : load a_i into q (multiplier/dividend), b_i into operand
//                  register (multiplicand/divisor), clear r
//   step_i       : perform one iteration
//   mode_i       : 0 multiply, 1 divide
//   hi_o, lo_o   : multiply -> {hi,lo} product; divide -> hi remainder,
//                  lo quotient
// -----------------------------------------------------------------------------
module hilo_iter_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);
    localparam int DW = DATA_WIDTH;

    logic [DW-1:0] r_q, r_d;
    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] opd_q, opd_d;

    logic [DW:0]   x;
    logic [DW:0]   y;
    logic          cin;
    logic [DW+1:0] sum;

    // Shared adder. Divide computes x - divisor as x + ~divisor + 1, so the
    // carry out (sum[DW+1]) is the "no borrow" quotient bit.
    always_comb begin
        x   = {1'b0, r_q};
        y   = '0;
        cin = 1'b0;
        if (mode_i) begin
            x   = {r_q, q_q[DW-1]};
            y   = ~{1'b0, opd_q};
            cin = 1'b1;
        end else if (q_q[0]) begin
            y   = {1'b0, opd_q};
        end
        sum = {1'b0, x} + {1'b0, y} + {{(DW+1){1'b0}}, cin};
    end

    always_comb begin
        r_d   = r_q;
        q_d   = q_q;
        opd_d = opd_q;
        if (load_i) begin
            r_d   = '0;
            q_d   = a_i;
            opd_d = b_i;
        end else if (step_i) begin
            if (mode_i) begin
                // Remainder stays below the divisor, so DW bits suffice.
                if (sum[DW+1]) begin
                    r_d = sum[DW-1:0];
                    q_d = {q_q[DW-2:0], 1'b1};
                end else begin
                    r_d = x[DW-1:0];
                    q_d = {q_q[DW-2:0], 1'b0};
                end
            end else begin
                // Shift {carry, acc, multiplier} right by one.
                r_d = sum[DW:1];
                q_d = {sum[0], q_q[DW-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q   <= '0;
            q_q   <= '0;
            opd_q <= '0;
        end else begin
            r_q   <= r_d;
            q_q   <= q_d;
            opd_q <= opd_d;
        end
    end

    assign hi_o = r_q;
    assign lo_o = q_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit
// HI/LO register pair with an iterative multiply/divide engine, MTHI/MTLO
// writes and a valid/ready handshake. Owns the control FSM, sign fix-up and
// HI/LO commit; the bit-serial datapath lives in hilo_iter_core.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : hilo_muldiv_unit_if.slave (request, status, out_hi/out_lo)
// Build option:
//   HILO_MADD_EN : when defined, op_codes 6/7 are signed multiply-accumulate
//                  / multiply-subtract into {HI,LO}; otherwise they are
//                  single-cycle no-ops that just pulse done.
// Latency: accept at E0, commit at E(DATA_WIDTH+1), done high the cycle after.
// -----------------------------------------------------------------------------
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] HI_RESET   = '0,
    parameter logic [DATA_WIDTH-1:0] LO_RESET   = '0
) (
    input  logic                clk,
    input  logic                reset,
    hilo_muldiv_unit_if.slave   bus
);
    localparam int DW    = DATA_WIDTH;
    localparam int CNT_W = hilo_cnt_w(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    hilo_state_e       state_q, state_d;
    hilo_op_e          op_q, op_d, op_in;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [DW-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d, dbz_q, dbz_d;

    logic              ready, accept, is_signed;
    logic              core_load, core_step, core_mode;
    logic [DW-1:0]     core_a, core_b, core_hi, core_lo;
    logic [2*DW-1:0]   prod;

    // Magnitude in DW+1 bits so that |MIN| is representable; the result
    // always fits in DW unsigned bits.
    function automatic logic [DW-1:0] mag(input logic [DW-1:0] v, input logic sgn);
        logic signed [DW:0] ext;
        ext = $signed({v[DW-1] & sgn, v});
        if (sgn && v[DW-1]) ext = -ext;
        return ext[DW-1:0];
    endfunction

    assign op_in     = hilo_op_e'(bus.op_code);
    assign accept    = bus.op_valid && ready;
    assign is_signed = op_in inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    assign core_a    = mag(bus.operand_a, is_signed);
    assign core_b    = mag(bus.operand_b, is_signed);

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op_in)
                        OP_MULT, OP_MULTU: state_d = ST_MUL;
                        OP_DIV, OP_DIVU: begin
                            if (bus.operand_b != '0) state_d = ST_DIV;
                        end
`ifdef HILO_MADD_EN
                        OP_MADD, OP_MSUB:  state_d = ST_MUL;
`endif
                        default:           state_d = ST_IDLE;
                    endcase
                end
            end
            ST_MUL, ST_DIV: if (cnt_q == LAST) state_d = ST_FIX;
            ST_FIX:         state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready     = (state_q == ST_IDLE);
        core_step = (state_q == ST_MUL) || (state_q == ST_DIV);
        core_mode = (state_q == ST_DIV);
        core_load = (state_q == ST_IDLE) && (state_d != ST_IDLE);
    end

    // Request capture, iteration count and sign fix-up / commit.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        prod      = {core_hi, core_lo};
        if (neg_res_q) prod = -prod;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = op_in;
                    cnt_d     = '0;
                    neg_res_d = is_signed & (bus.operand_a[DW-1] ^ bus.operand_b[DW-1]);
                    neg_rem_d = is_signed & bus.operand_a[DW-1];
                    case (op_in)
                        OP_MTHI: hi_d = bus.operand_a;
                        OP_MTLO: lo_d = bus.operand_a;
                        OP_DIV, OP_DIVU: begin
                            if (bus.operand_b == '0) begin
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end
                        end
`ifndef HILO_MADD_EN
                        OP_MADD, OP_MSUB: done_d = 1'b1;
`endif
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: cnt_d = cnt_q + CNT_W'(1);
            ST_FIX: begin
                done_d = 1'b1;
                case (op_q)
                    OP_DIV, OP_DIVU: begin
                        lo_d = neg_res_q ? -core_lo : core_lo;
                        hi_d = neg_rem_q ? -core_hi : core_hi;
                    end
`ifdef HILO_MADD_EN
                    OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod;
                    OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
                    default: {hi_d, lo_d} = prod;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= HI_RESET;
            lo_q      <= LO_RESET;
            op_q      <= OP_MULT;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    hilo_iter_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load_i (core_load),
        .step_i (core_step),
        .mode_i (core_mode),
        .a_i    (core_a),
        .b_i    (core_b),
        .hi_o   (core_hi),
        .lo_o   (core_lo)
    );

    assign bus.op_ready    = ready;
    assign bus.busy        = !ready;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.out_hi      = hi_q;
    assign bus.out_lo      = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_muldiv_unit
// Directed bench for hilo_muldiv_unit (DATA_WIDTH = 32): a table of
// single-operation vectors with hand-computed results, followed by
// hand-written sequences for MTHI/MTLO timing, requests held while busy,
// multiply-accumulate (HILO_MADD_EN builds) and reset during a divide.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    hilo_muldiv_unit_if #(.DATA_WIDTH(DW)) bif ();

    hilo_muldiv_unit #(
        .DATA_WIDTH (DW),
        .HI_RESET   (32'h0),
        .LO_RESET   (32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        keep;   // expected HI/LO are the values before the op
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;    // cycle (after accept) in which done is seen
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] m_hi, m_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bif.op_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bif.op_code   = op;
        bif.operand_a = a;
        bif.operand_b = b;
        bif.op_valid  = 1'b1;
    endtask

    // Single-cycle register write (MTHI/MTLO).
    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        wait_ready();
        drive(op, v, 32'h0);
        @(posedge clk); #1;
        bif.op_valid = 1'b0;
    endtask

    // Issue one operation and follow it to done, watching that HI/LO hold
    // their old values and busy/op_ready stay consistent meanwhile.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic dbz, output logic hold_ok,
                          output logic busy_ok);
        logic [31:0] hi0, lo0;
        wait_ready();
        hi0 = bif.out_hi;
        lo0 = bif.out_lo;
        drive(op, a, b);
        @(posedge clk); #1;
        bif.op_valid = 1'b0;
        lat = 0; dbz = 1'b0; hold_ok = 1'b1; busy_ok = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            if (bif.done) begin
                lat = c;
                dbz = bif.div_by_zero;
                if (bif.busy || !bif.op_ready) busy_ok = 1'b0;
                break;
            end
            if (bif.out_hi !== hi0 || bif.out_lo !== lo0) hold_ok = 1'b0;
            if (!bif.busy || bif.op_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int          lat;
        logic        dbz, hold_ok, busy_ok, found, done_seen;
        logic [31:0] eh, el;

        reset         = 1'b0;
        bif.op_valid  = 1'b0;
        bif.op_code   = 3'd0;
        bif.operand_a = 32'h0;
        bif.operand_b = 32'h0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bif.op_ready), 32'd1);
        check("rst_busy",  32'(bif.busy), 32'd0);
        check("rst_done",  32'(bif.done), 32'd0);
        check("rst_dbz",   32'(bif.div_by_zero), 32'd0);
        check("rst_hi",    bif.out_hi, 32'h0);
        check("rst_lo",    bif.out_lo, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // ---------------- vector table ----------------
        vecs.push_back('{OP_MULT,  32'hFFFFFFFD, 32'd5,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34});
        vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34});
        vecs.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, 1'b0, 34});
        vecs.push_back('{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'h80000001, 1'b0, 34});
        vecs.push_back('{OP_DIVU,  32'd100,      32'd7,        1'b0, 32'd2,        32'd14,       1'b0, 34});
        vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34});
        vecs.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34});
        vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 1'b0, 34});
        vecs.push_back('{OP_DIVU,  32'd5,        32'd0,        1'b1, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{OP_DIV,   32'd9,        32'd0,        1'b1, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'd1,        1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b0, 34});
        vecs.push_back('{OP_MULT,  32'h0,        32'h12345678, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 34});
`ifndef HILO_MADD_EN
        vecs.push_back('{OP_MADD,  32'd1,        32'd1,        1'b1, 32'h0,        32'h0,        1'b0, 1});
        vecs.push_back('{OP_MSUB,  32'd2,        32'd1,        1'b1, 32'h0,        32'h0,        1'b0, 1});
`endif

        m_hi = 32'h0;
        m_lo = 32'h0;
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, dbz, hold_ok, busy_ok);
            eh = vecs[i].keep ? m_hi : vecs[i].hi;
            el = vecs[i].keep ? m_lo : vecs[i].lo;
            check($sformatf("v%0d_hi", i),   bif.out_hi, eh);
            check($sformatf("v%0d_lo", i),   bif.out_lo, el);
            check($sformatf("v%0d_dbz", i),  32'(dbz), 32'(vecs[i].dbz));
            check($sformatf("v%0d_lat", i),  32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_hold", i), 32'(hold_ok), 32'd1);
            check($sformatf("v%0d_busy", i), 32'(busy_ok), 32'd1);
            m_hi = eh;
            m_lo = el;
        end

        // ---------------- MTHI then MTLO on consecutive edges ----------------
        wait_ready();
        drive(OP_MTHI, 32'h12345678, 32'h0);
        @(posedge clk); #1;
        check("mthi_hi", bif.out_hi, 32'h12345678);
        check("mthi_lo", bif.out_lo, m_lo);
        check("mthi_status", {30'd0, bif.done, bif.busy}, 32'd0);
        drive(OP_MTLO, 32'hCAFEBABE, 32'h0);
        @(posedge clk); #1;
        bif.op_valid = 1'b0;
        check("mtlo_lo", bif.out_lo, 32'hCAFEBABE);
        check("mtlo_hi", bif.out_hi, 32'h12345678);
        check("mtlo_status", {30'd0, bif.done, bif.busy}, 32'd0);

        // ---------------- MTLO held while MULTU is busy ----------------
        mt(OP_MTLO, 32'h5555AAAA);
        wait_ready();
        drive(OP_MULTU, 32'd3, 32'd4);
        @(posedge clk); #1;
        drive(OP_MTLO, 32'hCAFEBABE, 32'h0);
        hold_ok = 1'b1;
        found   = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (bif.done) begin
                found = 1'b1;
                break;
            end
            if (bif.out_lo !== 32'h5555AAAA) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        check("busy_mtlo_ignored", 32'(hold_ok), 32'd1);
        check("busy_mtlo_done", 32'(found), 32'd1);
        check("busy_mtlo_prod_lo", bif.out_lo, 32'd12);
        check("busy_mtlo_prod_hi", bif.out_hi, 32'd0);
        check("busy_mtlo_ready", 32'(bif.op_ready), 32'd1);
        @(posedge clk); #1;
        bif.op_valid = 1'b0;
        check("b2b_mtlo_lo", bif.out_lo, 32'hCAFEBABE);
        check("b2b_mtlo_hi", bif.out_hi, 32'd0);

`ifdef HILO_MADD_EN
        // ---------------- multiply-accumulate ----------------
        mt(OP_MTHI, 32'h0);
        mt(OP_MTLO, 32'hFFFFFFFF);
        vecs.delete();
        vecs.push_back('{OP_MADD, 32'd1,        32'd1, 1'b0, 32'h1, 32'h00000000, 1'b0, 34});
        vecs.push_back('{OP_MSUB, 32'd1,        32'd1, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0, 34});
        vecs.push_back('{OP_MSUB, 32'd2,        32'd1, 1'b0, 32'h0, 32'hFFFFFFFD, 1'b0, 34});
        vecs.push_back('{OP_MADD, 32'hFFFFFFFF, 32'd3, 1'b0, 32'h0, 32'hFFFFFFFA, 1'b0, 34});
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, dbz, hold_ok, busy_ok);
            check($sformatf("madd%0d_hi", i),  bif.out_hi, vecs[i].hi);
            check($sformatf("madd%0d_lo", i),  bif.out_lo, vecs[i].lo);
            check($sformatf("madd%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        end
`endif

        // ---------------- reset during a divide ----------------
        mt(OP_MTHI, 32'hDEADBEEF);
        wait_ready();
        drive(OP_DIV, 32'd100, 32'd7);
        @(posedge clk); #1;
        bif.op_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        check("rstdiv_hi", bif.out_hi, 32'h0);
        check("rstdiv_lo", bif.out_lo, 32'h0);
        check("rstdiv_ready", 32'(bif.op_ready), 32'd1);
        check("rstdiv_busy", 32'(bif.busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bif.done) done_seen = 1'b1;
        end
        check("rstdiv_no_done", 32'(done_seen), 32'd0);
        check("rstdiv_hi_after", bif.out_hi, 32'h0);
        check("rstdiv_lo_after", bif.out_lo, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
